// File: rtl/uart_clk_div_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_clk_div_if
// Description : Control/output bundle for the UART bit-rate clock divider.
//               The master drives the enable and ratio. The slave (the
//               divider) drives the divided clock.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_clk_div_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 clk_en;
    logic [DIV_WIDTH-1:0] div_ratio;
    logic                 div_clk;

    modport master (
        output clk_en,
        output div_ratio,
        input  div_clk
    );

    modport slave (
        input  clk_en,
        input  div_ratio,
        output div_clk
    );
endinterface
`default_nettype wire

// File: rtl/uart_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : uart_clk_div
// Description : Runtime-programmable integer divider that produces the UART
//               bit-rate clock from the reference clock.
//               - Even ratios give 50% duty.
//               - Odd ratios make the low phase one cycle longer than the
//                 high phase.
//               - A ratio below 2, or enable low, passes clk straight through.
//               Optional macro CLK_DIV_RATIO_SHADOW_EN latches the ratio at
//               period boundaries, so changes made mid-period never truncate
//               or stretch a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_clk_div #(
    parameter int DIV_WIDTH = 8
) (
    input wire            clk,
    input wire            rst,
    uart_clk_div_if.slave bus
);

    localparam logic [DIV_WIDTH-1:0] C_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] C_TWO = {{(DIV_WIDTH-2){1'b0}}, 2'b10};

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_div_q;

    logic                 w_active;
    logic [DIV_WIDTH-1:0] w_n;
    logic [DIV_WIDTH-1:0] w_t0;
    logic [DIV_WIDTH-1:0] w_t1;
    logic [DIV_WIDTH-1:0] w_t;
    logic [DIV_WIDTH-1:0] w_t_m1;
    logic                 w_phase_end;

    // The bypass decision always looks at the live ratio, even when shadowing.
    assign w_active = bus.clk_en && (bus.div_ratio >= C_TWO);

`ifdef CLK_DIV_RATIO_SHADOW_EN
    logic                 r_run;
    logic [DIV_WIDTH-1:0] r_ratio_q;

    // On the first active edge the shadow register is not loaded yet, so the
    // live ratio is used directly.
    assign w_n = r_run ? r_ratio_q : bus.div_ratio;

    // Shadow register: load it on entry to active and on each high-to-low toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run     <= 1'b0;
            r_ratio_q <= '0;
        end else begin
            r_run <= w_active;
            if (w_active && (!r_run || (r_div_q && w_phase_end))) begin
                r_ratio_q <= bus.div_ratio;
            end
        end
    end
`else
    assign w_n = bus.div_ratio;
`endif

    // (N+1)>>1 is formed as (N>>1) + N[0]. This cannot overflow, even for N = all ones.
    assign w_t0 = (w_n >> 1) + {{(DIV_WIDTH-1){1'b0}}, w_n[0]};
    assign w_t1 = w_n >> 1;
    assign w_t  = r_div_q ? w_t1 : w_t0;

    // A phase length is at least 1 whenever the divider is active.
    assign w_t_m1 = w_t - C_ONE;

    // ">=" ends the phase at once when the ratio shrinks below the cycles already spent.
    assign w_phase_end = (r_cnt >= w_t_m1);

    // Phase counter and divided level. They are held cleared while bypassed,
    // so that every entry to active starts with a full low phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div_q <= 1'b0;
        end else if (!w_active) begin
            r_cnt   <= '0;
            r_div_q <= 1'b0;
        end else if (w_phase_end) begin
            r_cnt   <= '0;
            r_div_q <= ~r_div_q;
        end else begin
            r_cnt   <= r_cnt + C_ONE;
        end
    end

    // The output mux is purely combinational. It adds no latency when
    // switching into bypass or into reset.
    assign bus.div_clk = rst ? 1'b0 : (w_active ? r_div_q : clk);

endmodule
`default_nettype wire

// File: tb/tb_uart_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_clk_div
// Description : Self-checking bench for uart_clk_div. A phase-timing model is
//               compared on both clock levels, with literal waveform checks
//               for the main scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_clk_div;

    localparam int DIV_WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_clk_div_if #(.DIV_WIDTH(DIV_WIDTH)) bus ();

    uart_clk_div #(.DIV_WIDTH(DIV_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: track when the current phase began (in edge numbers) and the
    // current level. A phase ends once it has lasted its length for the
    // ratio in force.
    // ------------------------------------------------------------------
    int m_cyc   = 0;
    int m_start = 0;
    int m_n     = 0;
    bit m_level = 1'b0;
    bit m_run   = 1'b0;

    always @(posedge clk or posedge rst) begin
        int n;
        int len;
        if (rst) begin
            m_level = 1'b0;
            m_run   = 1'b0;
        end else begin
            m_cyc++;
            if (!(bus.clk_en && bus.div_ratio >= 2)) begin
                m_level = 1'b0;
                m_run   = 1'b0;
            end else begin
                if (!m_run) begin
                    m_run   = 1'b1;
                    m_level = 1'b0;
                    m_start = m_cyc;
                    m_n     = int'(bus.div_ratio);
                end
`ifdef CLK_DIV_RATIO_SHADOW_EN
                n = m_n;
`else
                n = int'(bus.div_ratio);
`endif
                len = m_level ? (n / 2) : ((n + 1) / 2);
                if (m_cyc - m_start + 1 >= len) begin
                    if (m_level) m_n = int'(bus.div_ratio);
                    m_level = ~m_level;
                    m_start = m_cyc + 1;
                end
            end
        end
    end

    function automatic logic model_out(input logic clk_level);
        if (rst) return 1'b0;
        if (bus.clk_en && bus.div_ratio >= 2) return m_level;
        return clk_level;
    endfunction

    // Continuous comparison against the model on both clock levels.
    always @(posedge clk) begin
        #1 check("model_hi", {31'd0, bus.div_clk}, {31'd0, model_out(1'b1)});
    end
    always @(negedge clk) begin
        #1 check("model_lo", {31'd0, bus.div_clk}, {31'd0, model_out(1'b0)});
    end

    // Sample the output once per cycle, just after each falling edge, into a shift register.
    task automatic grab(input int n, output logic [31:0] s);
        s = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 s = {s[30:0], bus.div_clk};
        end
        #1;
    endtask

    // Leave active for two edges, then enable with ratio r (at negedge+2).
    task automatic enter(input int r);
        bus.clk_en = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        bus.div_ratio = DIV_WIDTH'(r);
        bus.clk_en    = 1'b1;
    endtask

    logic [31:0] s;
    logic        samp [0:399];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        int c;
        bus.clk_en    = 1'b1;
        bus.div_ratio = 8'd4;

        // 1. Reset holds output low on both clock levels; release gives period 4.
        repeat (2) @(negedge clk);
        #1 check("reset_lo", {31'd0, bus.div_clk}, 32'd0);
        @(posedge clk);
        #2 check("reset_hi", {31'd0, bus.div_clk}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        grab(8, s);
        check("n4_pattern", {24'd0, s[7:0]}, {24'd0, 8'b0110_0110});
        repeat (32) @(negedge clk);
        #2;

        // 2. Odd ratios.
        enter(5);
        grab(10, s);
        check("n5_pattern", {22'd0, s[9:0]}, {22'd0, 10'b00_1100_0110});
        enter(255);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1 samp[i] = bus.div_clk;
        end
        #1;
        a = 400; b = 400; c = 400;
        for (int i = 0; i < 400; i++) if (a == 400 && samp[i]) a = i;
        for (int i = 0; i < 400; i++) if (b == 400 && i > a && !samp[i]) b = i;
        for (int i = 0; i < 400; i++) if (c == 400 && i > b && samp[i]) c = i;
        check("n255_high_len", b - a, 32'd127);
        check("n255_low_len",  c - b, 32'd128);

        // 3. Bypass for ratio 0, ratio 1 and enable low; then ratio 2 toggles every edge.
        bus.clk_en = 1'b1; bus.div_ratio = 8'd0;
        @(posedge clk); #1 check("byp_r0_hi", {31'd0, bus.div_clk}, 32'd1);
        @(negedge clk); #1 check("byp_r0_lo", {31'd0, bus.div_clk}, 32'd0);
        #1 bus.div_ratio = 8'd1;
        @(posedge clk); #1 check("byp_r1_hi", {31'd0, bus.div_clk}, 32'd1);
        @(negedge clk); #1 check("byp_r1_lo", {31'd0, bus.div_clk}, 32'd0);
        #1 bus.clk_en = 1'b0; bus.div_ratio = 8'd9;
        @(posedge clk); #1 check("byp_en0_hi", {31'd0, bus.div_clk}, 32'd1);
        @(negedge clk); #1 check("byp_en0_lo", {31'd0, bus.div_clk}, 32'd0);
        #1 bus.div_ratio = 8'd2; bus.clk_en = 1'b1;
        grab(6, s);
        check("n2_pattern", {26'd0, s[5:0]}, {26'd0, 6'b10_1010});

        // 4. Ratio 8 -> 2 after the second low-phase edge.
        enter(8);
        s = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 s = {s[30:0], bus.div_clk};
            if (i == 1) #1 bus.div_ratio = 8'd2;
        end
        #1;
`ifdef CLK_DIV_RATIO_SHADOW_EN
        check("ratio_change", {22'd0, s[9:0]}, {22'd0, 10'b00_0111_1010});
`else
        check("ratio_change", {22'd0, s[9:0]}, {22'd0, 10'b00_1010_1010});
`endif

        // 5. Enable drop in the high phase bypasses at once; re-enable starts with a full low phase.
        enter(4);
        grab(2, s);
        check("pre_drop", {30'd0, s[1:0]}, {30'd0, 2'b01});
        bus.clk_en = 1'b0;
        #1 check("drop_same_cycle", {31'd0, bus.div_clk}, 32'd0);
        @(posedge clk); #1 check("drop_bypass_hi", {31'd0, bus.div_clk}, 32'd1);
        @(negedge clk); #2;
        bus.div_ratio = 8'd6; bus.clk_en = 1'b1;
        grab(6, s);
        check("reenable_n6", {26'd0, s[5:0]}, {26'd0, 6'b00_1110});

        // 6. Asynchronous reset in the high phase, then restart from low.
        enter(4);
        grab(2, s);
        @(posedge clk);
        #2 check("pre_rst_hi", {31'd0, bus.div_clk}, 32'd1);
        #1 rst = 1'b1;
        #1 check("async_rst", {31'd0, bus.div_clk}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        grab(4, s);
        check("post_rst_n4", {28'd0, s[3:0]}, {28'd0, 4'b0110});

        repeat (2) @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
